// File: rtl/link_align_pkg.sv
`default_nettype none
// ============================================================================
// link_align_pkg: state encoding and default constants for link_align_ctrl
// Revision: 1.0
// ============================================================================

package link_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_OBSERVE = 3'd3,
    ST_SLIP    = 3'd4,
    ST_LOCKED  = 3'd5,
    ST_FAIL    = 3'd6
  } align_state_t;

  localparam int DEF_LOCK_FRAMES   = 1024;
  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int DEF_SLIP_MAX      = 40;
  localparam int DEF_UNLOCK_ERRORS = 4;
  localparam int DEF_ERR_CNT_W     = 16;
  localparam int SLIP_CNT_W        = 6;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter: saturating up-counter; clear and increment together yield 1
// Revision: 1.0
// ============================================================================

module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk40,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk40) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? WIDTH'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/link_align_ctrl.sv
`default_nettype none
// ============================================================================
// link_align_ctrl: bitslip word-boundary search, lock and relock for one link
// Revision: 1.0
// ============================================================================

module link_align_ctrl
  import link_align_pkg::*;
#(
  parameter int LOCK_FRAMES   = DEF_LOCK_FRAMES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SLIP_MAX      = DEF_SLIP_MAX,
  parameter int UNLOCK_ERRORS = DEF_UNLOCK_ERRORS,
  parameter int ERR_CNT_W     = DEF_ERR_CNT_W
) (
  input  logic                  clk40,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  dataValid,
  input  logic                  checkNoError,
  input  logic                  errClear,
  output logic                  chkReset,
  output logic                  bitslip,
  output logic                  locked,
  output logic                  alignFail,
  output logic [SLIP_CNT_W-1:0] slipCount,
  output logic [ERR_CNT_W-1:0]  errCount,
  output logic [2:0]            state
);

  localparam int GOOD_W   = $clog2(LOCK_FRAMES + 1);
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int LOSS_W   = $clog2(UNLOCK_ERRORS + 1);

  localparam logic [GOOD_W-1:0]     GOOD_LAST   = GOOD_W'(LOCK_FRAMES - 1);
  localparam logic [SETTLE_W-1:0]   SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [LOSS_W-1:0]     LOSS_LAST   = LOSS_W'(UNLOCK_ERRORS - 1);
  localparam logic [SLIP_CNT_W-1:0] SLIP_LAST   = SLIP_CNT_W'(SLIP_MAX - 1);

  align_state_t          cur_state;
  align_state_t          next_state;
  logic [GOOD_W-1:0]     good_cnt;
  logic [SETTLE_W-1:0]   settle_cnt;
  logic [LOSS_W-1:0]     loss_cnt;
  logic                  err_event;
  logic                  good_frame;
  logic                  good_done;

  assign err_event  = dataValid & ~checkNoError;
  assign good_frame = dataValid & checkNoError;
  assign good_done  = good_frame && (good_cnt >= GOOD_LAST);
  assign state      = cur_state;

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      ST_IDLE:    if (enable) next_state = ST_CLEAR;
      ST_CLEAR:   next_state = ST_SETTLE;
      ST_SETTLE:  if (settle_cnt >= SETTLE_LAST) next_state = ST_OBSERVE;
      ST_OBSERVE: begin
        if (err_event)      next_state = (slipCount >= SLIP_LAST) ? ST_FAIL : ST_SLIP;
        else if (good_done) next_state = ST_LOCKED;
      end
      ST_SLIP:    next_state = ST_CLEAR;
      ST_LOCKED:  if (err_event && (loss_cnt >= LOSS_LAST)) next_state = ST_CLEAR;
      ST_FAIL:    next_state = ST_FAIL;
      default:    next_state = ST_IDLE;
    endcase
    if (!enable) next_state = ST_IDLE;
  end

  // Outputs are registered from next_state so they line up with the state register.
  always_ff @(posedge clk40) begin
    if (!reset) begin
      cur_state  <= ST_IDLE;
      chkReset   <= 1'b0;
      bitslip    <= 1'b0;
      locked     <= 1'b0;
      alignFail  <= 1'b0;
      slipCount  <= '0;
      settle_cnt <= '0;
      good_cnt   <= '0;
      loss_cnt   <= '0;
    end else begin
      cur_state <= next_state;
      chkReset  <= (next_state == ST_SETTLE) || (next_state == ST_OBSERVE) ||
                   (next_state == ST_SLIP)   || (next_state == ST_LOCKED);
      bitslip   <= (next_state == ST_SLIP);
      locked    <= (next_state == ST_LOCKED);
      alignFail <= (next_state == ST_FAIL);

      if (next_state == ST_IDLE) begin
        slipCount <= '0;
      end else if (next_state == ST_SLIP && cur_state != ST_SLIP) begin
        slipCount <= (slipCount >= SLIP_LAST) ? '0 : slipCount + 1'b1;
      end

      if (cur_state == ST_SETTLE) begin
        if (settle_cnt < SETTLE_LAST) settle_cnt <= settle_cnt + 1'b1;
      end else begin
        settle_cnt <= '0;
      end

      case (cur_state)
        ST_OBSERVE: begin
          if (good_done)       good_cnt <= '0;
          else if (good_frame) good_cnt <= good_cnt + 1'b1;
        end
        ST_LOCKED: begin
          if (err_event || good_done) good_cnt <= '0;
          else if (good_frame)        good_cnt <= good_cnt + 1'b1;
        end
        default: good_cnt <= '0;
      endcase

      // Loss counter only lives in LOCKED; every entry to LOCKED comes through CLEAR.
      if (cur_state == ST_LOCKED) begin
        if (err_event) begin
          if (loss_cnt < LOSS_W'(UNLOCK_ERRORS)) loss_cnt <= loss_cnt + 1'b1;
        end else if (good_done) begin
          loss_cnt <= '0;
        end
      end else begin
        loss_cnt <= '0;
      end
    end
  end

  sat_counter #(
    .WIDTH (ERR_CNT_W)
  ) u_err_cnt (
    .clk40 (clk40),
    .reset (reset),
    .clr   (errClear),
    .inc   (err_event && (cur_state == ST_LOCKED)),
    .count (errCount)
  );

endmodule

`default_nettype wire

// File: tb/tb_link_align_ctrl.sv
`default_nettype none
// ============================================================================
// tb_link_align_ctrl: scoreboard bench for link_align_ctrl (ERR_CNT_W = 4)
// Revision: 1.0
// ============================================================================

module tb_link_align_ctrl;

  logic       clk40 = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       dataValid = 1'b0;
  logic       checkNoError = 1'b1;
  logic       errClear = 1'b0;
  logic       chkReset;
  logic       bitslip;
  logic       locked;
  logic       alignFail;
  logic [5:0] slipCount;
  logic [3:0] errCount;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int slip_pulses = 0;
  int exp_slip_q[$];

  link_align_ctrl #(
    .LOCK_FRAMES   (1024),
    .SETTLE_CYCLES (16),
    .SLIP_MAX      (40),
    .UNLOCK_ERRORS (4),
    .ERR_CNT_W     (4)
  ) dut (
    .clk40        (clk40),
    .reset        (reset),
    .enable       (enable),
    .dataValid    (dataValid),
    .checkNoError (checkNoError),
    .errClear     (errClear),
    .chkReset     (chkReset),
    .bitslip      (bitslip),
    .locked       (locked),
    .alignFail    (alignFail),
    .slipCount    (slipCount),
    .errCount     (errCount),
    .state        (state)
  );

  always #5 clk40 = ~clk40;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs are applied for one rising edge; return at the following falling edge.
  task automatic tick(input logic dv, input logic ne, input logic clr);
    dataValid    = dv;
    checkNoError = ne;
    errClear     = clr;
    @(negedge clk40);
    dataValid    = 1'b0;
    checkNoError = 1'b1;
    errClear     = 1'b0;
  endtask

  task automatic wait_observe(output int settle_n);
    settle_n = 0;
    for (int i = 0; i < 100 && state != 3'd3; i++) begin
      if (state == 3'd2) settle_n++;
      tick(1'b0, 1'b1, 1'b0);
    end
    check("observe_reached", 32'(state), 3);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, 32'(state), 0);
    check({tag, "_chkReset"}, 32'(chkReset), 0);
    check({tag, "_bitslip"}, 32'(bitslip), 0);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_alignFail"}, 32'(alignFail), 0);
    check({tag, "_slipCount"}, 32'(slipCount), 0);
    check({tag, "_errCount"}, 32'(errCount), 0);
  endtask

  task automatic good_frames(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 1'b0);
  endtask

  // Error in OBSERVE that should cause a slip; the bitslip monitor pops the expectation.
  task automatic slip_error(input int exp_count);
    int n;
    exp_slip_q.push_back(exp_count);
    tick(1'b1, 1'b0, 1'b0);
    check("slip_state", 32'(state), 4);
    check("slip_pulse", 32'(bitslip), 1);
    tick(1'b0, 1'b1, 1'b0);
    check("clear_state", 32'(state), 1);
    check("clear_chkReset", 32'(chkReset), 0);
    check("clear_bitslip", 32'(bitslip), 0);
    wait_observe(n);
    check("settle_len", 32'(n), 16);
  endtask

  // Bitslip monitor: single-cycle pulses, spacing and expected slipCount.
  int  cyc = 0;
  int  last_slip = -1000;
  logic prev_bs = 1'b0;
  always @(negedge clk40) begin
    cyc++;
    if (bitslip) begin
      slip_pulses++;
      check("slip_single", 32'(prev_bs), 0);
      check("slip_gap_ok", 32'((cyc - last_slip) >= 19), 1);
      last_slip = cyc;
      if (exp_slip_q.size() == 0) check("slip_unexpected", 1, 0);
      else check("slip_count", 32'(slipCount), 32'(exp_slip_q.pop_front()));
    end
    prev_bs = bitslip;
  end

  initial begin
    int n;
    int exp_err;

    // Reset state
    repeat (3) @(negedge clk40);
    check_reset_vals("rst");
    reset = 1'b1;
    tick(1'b0, 1'b1, 1'b0);
    check("idle_hold", 32'(state), 0);

    // 1: immediate lock on a clean stream
    enable = 1'b1;
    wait_observe(n);
    check("t1_settle_len", 32'(n), 16);
    check("t1_chkReset_obs", 32'(chkReset), 1);
    good_frames(1023);
    check("t1_not_yet_locked", 32'(locked), 0);
    check("t1_state_obs", 32'(state), 3);
    good_frames(1);
    check("t1_locked", 32'(locked), 1);
    check("t1_state_locked", 32'(state), 5);
    check("t1_slipCount", 32'(slipCount), 0);
    check("t1_no_slips", 32'(slip_pulses), 0);

    // 2: lock after three slips
    enable = 1'b0;
    tick(1'b0, 1'b1, 1'b0);
    check("t2_idle", 32'(state), 0);
    check("t2_unlocked", 32'(locked), 0);
    enable = 1'b1;
    wait_observe(n);
    for (int k = 1; k <= 3; k++) slip_error(k);
    good_frames(1024);
    check("t2_locked", 32'(locked), 1);
    check("t2_slipCount", 32'(slipCount), 3);
    check("t2_pulses", 32'(slip_pulses), 3);

    // 4: loss of lock after the fourth error
    for (int k = 1; k <= 3; k++) begin
      tick(1'b1, 1'b0, 1'b0);
      good_frames(10);
    end
    check("t4_still_locked", 32'(locked), 1);
    check("t4_errCount3", 32'(errCount), 3);
    tick(1'b1, 1'b0, 1'b0);
    check("t4_unlocked", 32'(locked), 0);
    check("t4_state_clear", 32'(state), 1);
    check("t4_chkReset", 32'(chkReset), 0);
    check("t4_slipCount", 32'(slipCount), 3);
    check("t4_errCount4", 32'(errCount), 4);
    wait_observe(n);
    good_frames(1024);
    check("t4_relocked", 32'(locked), 1);

    // 5: saturating error counter and clear
    tick(1'b0, 1'b1, 1'b1);
    check("t5_cleared", 32'(errCount), 0);
    exp_err = 0;
    for (int g = 0; g < 6; g++) begin
      for (int e = 0; e < 3; e++) begin
        tick(1'b1, 1'b0, 1'b0);
        exp_err++;
        tick(1'b1, 1'b1, 1'b0);
      end
      check("t5_errCount", 32'(errCount), (exp_err > 15) ? 15 : exp_err);
      check("t5_locked", 32'(locked), 1);
      good_frames(1030);
    end
    tick(1'b1, 1'b0, 1'b1);
    check("t5_clr_plus_err", 32'(errCount), 1);
    check("t5_locked_after", 32'(locked), 1);

    // 3: alignment failure
    enable = 1'b0;
    tick(1'b0, 1'b1, 1'b0);
    enable = 1'b1;
    wait_observe(n);
    slip_pulses = 0;
    for (int k = 1; k <= 39; k++) slip_error(k);
    check("t3_pulses", 32'(slip_pulses), 39);
    check("t3_slipCount39", 32'(slipCount), 39);
    tick(1'b1, 1'b0, 1'b0);
    check("t3_fail_state", 32'(state), 6);
    check("t3_alignFail", 32'(alignFail), 1);
    check("t3_chkReset", 32'(chkReset), 0);
    check("t3_no_extra_slip", 32'(bitslip), 0);
    good_frames(5);
    check("t3_fail_held", 32'(state), 6);
    enable = 1'b0;
    tick(1'b0, 1'b1, 1'b0);
    check("t3_idle", 32'(state), 0);
    check("t3_slipCount0", 32'(slipCount), 0);
    check("t3_alignFail_off", 32'(alignFail), 0);

    // 6: reset during SETTLE
    enable = 1'b1;
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("t6_in_settle", 32'(state), 2);
    check("t6_chkReset_settle", 32'(chkReset), 1);
    reset = 1'b0;
    tick(1'b0, 1'b1, 1'b0);
    check_reset_vals("t6");
    reset = 1'b1;
    enable = 1'b0;

    check("scoreboard_empty", 32'(exp_slip_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/link_align_ctrl.md
# link_align_ctrl

Word-alignment controller for one ETROC2 readout link. It sits between the 40-bit deserializer and the frame-identifier stream checker. It holds the checker in reset, issues bitslip pulses to the deserializer, and uses the checker's `noError` verdict to search for the correct word boundary. Once aligned it declares lock, then monitors the link and relocks after repeated frame errors.

## Interface

Parameters:
- `LOCK_FRAMES`, 1024: consecutive error-free valid frames needed to declare lock.
- `SETTLE_CYCLES`, 16: clk40 cycles to wait after releasing checker reset before observing.
- `SLIP_MAX`, 40: number of distinct bit positions; `slipCount` wraps modulo this value.
- `UNLOCK_ERRORS`, 4: error events while locked that force a relock.
- `ERR_CNT_W`, 16: width of the error counter.

Ports:
- `clk40`  in  1  40 MHz clock.
- `reset`  in  1  synchronous, active-low.
- `enable`  in  1  run alignment; low forces IDLE.
- `dataValid`  in  1  frame strobe, same strobe fed to the checker.
- `checkNoError`  in  1  `noError` output of the stream checker.
- `errClear`  in  1  one-cycle pulse; clears `errCount`.
- `chkReset`  out  1  active-low reset to the checker.
- `bitslip`  out  1  one-cycle slip request to the deserializer.
- `locked`  out  1  alignment achieved.
- `alignFail`  out  1  all `SLIP_MAX` positions tried without lock.
- `slipCount`  out  6  number of slips issued since leaving IDLE, modulo `SLIP_MAX`.
- `errCount`  out  `ERR_CNT_W`  saturating count of error events while LOCKED.
- `state`  out  3  current FSM state, for debug.

## Operation

- **Error event:** `dataValid & !checkNoError`.
- **Good frame:** `dataValid & checkNoError`.

States (`state` encoding in brackets):
- **IDLE [0]:** `chkReset` = 0, `slipCount` = 0, `locked` = 0, `alignFail` = 0. Goes to CLEAR when `enable` = 1.
- **CLEAR [1]:** `chkReset` = 0 for exactly one cycle; the good-frame counter and the loss counter are zeroed. Goes to SETTLE.
- **SETTLE [2]:** `chkReset` = 1; counts `SETTLE_CYCLES` clk40 cycles, then goes to OBSERVE. Events arriving here are ignored.
- **OBSERVE [3]:** `chkReset` = 1; each good frame increments the good-frame counter.
  - When the counter reaches `LOCK_FRAMES`, go to LOCKED.
  - On an error event, go to FAIL if `slipCount == SLIP_MAX-1`, otherwise go to SLIP.
- **SLIP [4]:** `bitslip` = 1 for one cycle and `slipCount` increments. Goes to CLEAR.
- **LOCKED [5]:** `locked` = 1, `chkReset` = 1.
  - Each error event increments `errCount` (saturating) and the loss counter, and zeroes the good-frame counter.
  - `LOCK_FRAMES` consecutive good frames zero the loss counter.
  - When the loss counter reaches `UNLOCK_ERRORS`, go to CLEAR with `locked` = 0. `slipCount` is retained, so the search resumes from the current position.
- **FAIL [6]:** `alignFail` = 1, `chkReset` = 0. Held until `enable` = 0.

Priority and boundary rules:
- `enable` = 0 in any state: go to IDLE on the next edge. This has priority over all other transitions.
- `errClear` and an error event in the same cycle: `errCount` = 1.
- `errCount` holds at all-ones and never wraps. It is cleared only by `reset` or `errClear`.
- Counters saturate or compare with `>=` so they never wrap mid-state.

## Timing

- All outputs are registered.
- Reset values: `state` = IDLE, `chkReset` = 0, `bitslip` = 0, `locked` = 0, `alignFail` = 0, `slipCount` = 0, `errCount` = 0.
- Error event sampled in OBSERVE at edge t:
  - `bitslip` high during cycle t+1 (state SLIP);
  - `chkReset` low during t+2 (CLEAR);
  - SETTLE occupies t+3 .. t+2+`SETTLE_CYCLES`;
  - OBSERVE resumes at t+3+`SETTLE_CYCLES`.
- Lock: the `LOCK_FRAMES`-th good frame sampled at edge t gives `locked` = 1 from t+1.
- Unlock: the `UNLOCK_ERRORS`-th error sampled at t gives `locked` = 0 and `chkReset` = 0 at t+1.
- `bitslip` is never high for two consecutive cycles. Minimum spacing between slips is `SETTLE_CYCLES` + 3 cycles.

## Structure

- Package `link_align_pkg` holds:
  - the state enum (3-bit, encodings above);
  - default parameter constants;
  - the `slipCount` width constant (6).
- One sub-module, `sat_counter` (parameterized width, increment, clear; clear-plus-increment yields 1). It is used for `errCount` and may also be used for the loss counter.

## Test plan

1. **Immediate lock.** Reset, `enable` = 1, a clean stream with `checkNoError` = 1 on every valid frame → `locked` = 1 after exactly 1024 valid frames; `slipCount` = 0; `bitslip` never asserted.
2. **Lock after slips.** Error events injected until the third slip completes, then a clean stream → exactly 3 single-cycle `bitslip` pulses, each spaced ≥ 19 cycles apart; `slipCount` = 3; `locked` = 1.
3. **Alignment failure.** Permanent errors → 39 slips; the 40th error gives `alignFail` = 1 and `chkReset` = 0; dropping `enable` gives `state` = 0 and `slipCount` = 0 the next cycle.
4. **Loss of lock.** While locked, 3 errors spaced by fewer than 1024 good frames → still locked with `errCount` = 3; a 4th error → `locked` = 0 next cycle, state CLEAR, `slipCount` unchanged.
5. **Error counter and clear.** `ERR_CNT_W` = 4, more than 15 errors while locked with good-frame gaps preventing unlock → `errCount` holds at 15; `errClear` coincident with an error event → `errCount` = 1.
6. **Reset mid-operation.** `reset` low during SETTLE → next cycle all outputs at reset values and state IDLE.
